// File: rtl/memory_cycle.sv
// memory_cycle: M-to-W pipeline stage that turns loads and stores into a
// registered request/acknowledge transaction on the data-memory port.
// The M stage is held with stall_M while a request is outstanding. The W
// bundle receives a bubble for every cycle that does not retire an
// instruction. Misaligned accesses and acknowledge timeouts are dropped and
// recorded in sticky error flags.
module memory_cycle #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   // M-stage bundle
   input  logic        regwrt_M,
   input  logic        memwrite_M,
   input  logic        resultctrl_M,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PC_1DEM,
   input  logic [31:0] writedata_M,
   input  logic [31:0] ALUresult_M,
   output logic        stall_M,
   // data-memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   // W-stage bundle
   output logic        regwrt_W,
   output logic        resultctrl_W,
   output logic [4:0]  RD_W,
   output logic [31:0] PC_1DEMW,
   output logic [31:0] ALUresult_W,
   output logic [31:0] ReadData_W,
   // sticky error flags
   output logic        err_misalign,
   output logic        err_timeout
);

   // The REQ-cycle counter is 8 bits wide because TIMEOUT never exceeds 255.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   typedef struct packed {
      logic        regwrt;
      logic        resultctrl;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rdata;
   } wbundle_t;

   // A bubble retires nothing: no register write and all data fields cleared.
   function automatic wbundle_t bubble();
      wbundle_t b;
      b = '0;
      return b;
   endfunction

   // Word address of an access. The two low bits are forced to zero because
   // only aligned accesses ever reach the memory port.
   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   wbundle_t    w_q, w_d;

   logic        err_mis_q, err_mis_d;
   logic        err_to_q, err_to_d;

   logic        mem_op;
   logic        is_load;
   logic        aligned;
   logic        timeout;
   logic        stall;

   // A store takes priority when both the store and load requests are set,
   // so only a pure load returns memory data to W.
   assign mem_op  = memwrite_M | resultctrl_M;
   assign is_load = resultctrl_M & ~memwrite_M;
   assign aligned = (ALUresult_M[1:0] == 2'b00);
   // An acknowledge on the last permitted cycle takes precedence over the timeout.
   assign timeout = (state_q == ST_REQ) & ~mem_ack & (cnt_q == CNT_LAST);

   // Next-state, request, W bundle, error and stall decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      w_d         = bubble();
      err_mis_d   = err_mis_q;
      err_to_d    = err_to_q;
      stall       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_op && aligned) begin
               // Issue the request. The instruction waits in M until the
               // acknowledge arrives, so W gets a bubble meanwhile.
               state_d     = ST_REQ;
               cnt_d       = 8'd0;
               mem_req_d   = 1'b1;
               mem_we_d    = memwrite_M;
               mem_addr_d  = word_addr(ALUresult_M);
               mem_wdata_d = writedata_M;
               stall       = 1'b1;
            end else if (mem_op) begin
               // A misaligned access is dropped without stalling the pipeline.
               err_mis_d = 1'b1;
            end else begin
               w_d.regwrt     = regwrt_M;
               w_d.resultctrl = resultctrl_M;
               w_d.rd         = RD_M;
               w_d.pc         = PC_1DEM;
               w_d.alu        = ALUresult_M;
               w_d.rdata      = 32'd0;
            end
         end

         ST_REQ: begin
            if (mem_ack) begin
               state_d        = ST_IDLE;
               cnt_d          = 8'd0;
               mem_req_d      = 1'b0;
               mem_we_d       = 1'b0;
               w_d.regwrt     = regwrt_M;
               w_d.resultctrl = is_load;
               w_d.rd         = RD_M;
               w_d.pc         = PC_1DEM;
               w_d.alu        = ALUresult_M;
               w_d.rdata      = is_load ? mem_rdata : 32'd0;
            end else if (timeout) begin
               // Abandon the access. Releasing the stall lets the upstream
               // stage move on past the failed instruction.
               state_d   = ST_IDLE;
               cnt_d     = 8'd0;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               err_to_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
               stall = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and REQ-cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory request registers. These stay constant for the whole REQ period.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // W-stage pipeline register.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_q <= bubble();
      end else begin
         w_q <= w_d;
      end
   end

   // Sticky error flags. Only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_mis_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         err_mis_q <= err_mis_d;
         err_to_q  <= err_to_d;
      end
   end

   assign stall_M      = stall;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign regwrt_W     = w_q.regwrt;
   assign resultctrl_W = w_q.resultctrl;
   assign RD_W         = w_q.rd;
   assign PC_1DEMW     = w_q.pc;
   assign ALUresult_W  = w_q.alu;
   assign ReadData_W   = w_q.rdata;
   assign err_misalign = err_mis_q;
   assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Testbench for memory_cycle. Each instruction is modelled as a single
// transaction. Its cycle count, the stall and request windows, and the W
// result it retires are computed from the ack delay chosen for that
// instruction.
module tb_memory_cycle;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        regwrt_M, memwrite_M, resultctrl_M;
   logic [4:0]  RD_M;
   logic [31:0] PC_1DEM, writedata_M, ALUresult_M;
   logic        stall_M;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        regwrt_W, resultctrl_W;
   logic [4:0]  RD_W;
   logic [31:0] PC_1DEMW, ALUresult_W, ReadData_W;
   logic        err_misalign, err_timeout;

   always #5 clk = ~clk;

   memory_cycle #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .regwrt_M(regwrt_M), .memwrite_M(memwrite_M), .resultctrl_M(resultctrl_M),
      .RD_M(RD_M), .PC_1DEM(PC_1DEM), .writedata_M(writedata_M), .ALUresult_M(ALUresult_M),
      .stall_M(stall_M),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .regwrt_W(regwrt_W), .resultctrl_W(resultctrl_W), .RD_W(RD_W),
      .PC_1DEMW(PC_1DEMW), .ALUresult_W(ALUresult_W), .ReadData_W(ReadData_W),
      .err_misalign(err_misalign), .err_timeout(err_timeout)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Expected W bundle and error flags after the most recent retirement edge.
   logic        ew_rw, ew_rc;
   logic [4:0]  ew_rd;
   logic [31:0] ew_pc, ew_alu, ew_data;
   logic        e_mis, e_to;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_bubble();
      ew_rw = 1'b0; ew_rc = 1'b0; ew_rd = 5'd0;
      ew_pc = 32'd0; ew_alu = 32'd0; ew_data = 32'd0;
   endtask

   task automatic check_w(input string tag);
      chk({tag, ".regwrt_W"},     32'(regwrt_W),     32'(ew_rw));
      chk({tag, ".resultctrl_W"}, 32'(resultctrl_W), 32'(ew_rc));
      chk({tag, ".RD_W"},         32'(RD_W),         32'(ew_rd));
      chk({tag, ".PC_1DEMW"},     PC_1DEMW,          ew_pc);
      chk({tag, ".ALUresult_W"},  ALUresult_W,       ew_alu);
      chk({tag, ".ReadData_W"},   ReadData_W,        ew_data);
      chk({tag, ".err_misalign"}, 32'(err_misalign), 32'(e_mis));
      chk({tag, ".err_timeout"},  32'(err_timeout),  32'(e_to));
   endtask

   // Present one instruction starting at a negative edge. d is the REQ cycle
   // (1-based) in which the memory acknowledges. Values above TO mean no ack.
   task automatic run_op(input string tag, input logic rw, input logic mw, input logic rc,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                         input logic [31:0] alu, input int d);
      logic        memop, go, ld;
      logic [31:0] rdata;
      int          n;
      memop = mw | rc;
      go    = memop && (alu[1:0] == 2'b00);
      ld    = rc & ~mw;
      n     = go ? (((d <= TO) ? d : TO) + 1) : 1;
      rdata = $urandom;
      regwrt_M = rw; memwrite_M = mw; resultctrl_M = rc;
      RD_M = rd; PC_1DEM = pc; writedata_M = wd; ALUresult_M = alu;
      for (int c = 1; c <= n; c++) begin
         if (c > 1) @(negedge clk);
         // An ack during the first (IDLE) cycle is noise and must be ignored.
         if (c == 1) mem_ack = 1'($urandom_range(0, 1));
         else        mem_ack = (c - 1 == d);
         mem_rdata = mem_ack ? rdata : $urandom;
         #1;
         chk({tag, ".stall_M"}, 32'(stall_M), 32'(c < n));
         if (c == 1) begin
            check_w(tag);
            chk({tag, ".mem_req_idle"}, 32'(mem_req), 32'd0);
         end else begin
            chk({tag, ".mem_req"},   32'(mem_req), 32'd1);
            chk({tag, ".mem_addr"},  mem_addr,     {alu[31:2], 2'b00});
            chk({tag, ".mem_we"},    32'(mem_we),  32'(mw));
            chk({tag, ".mem_wdata"}, mem_wdata,    wd);
            chk({tag, ".bubble"},    {25'd0, regwrt_W, resultctrl_W, RD_W}, 32'd0);
            chk({tag, ".bubble_alu"}, ALUresult_W, 32'd0);
         end
      end
      if (!memop) begin
         ew_rw = rw; ew_rc = rc; ew_rd = rd; ew_pc = pc; ew_alu = alu; ew_data = 32'd0;
      end else if (!go) begin
         model_bubble(); e_mis = 1'b1;
      end else if (d <= TO) begin
         ew_rw = rw; ew_rc = ld; ew_rd = rd; ew_pc = pc; ew_alu = alu;
         ew_data = ld ? rdata : 32'd0;
      end else begin
         model_bubble(); e_to = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic zero_inputs();
      regwrt_M = 0; memwrite_M = 0; resultctrl_M = 0; RD_M = 0;
      PC_1DEM = 0; writedata_M = 0; ALUresult_M = 0; mem_ack = 0; mem_rdata = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".mem_req"},   32'(mem_req), 32'd0);
      chk({tag, ".mem_we"},    32'(mem_we),  32'd0);
      chk({tag, ".mem_addr"},  mem_addr,     32'd0);
      chk({tag, ".mem_wdata"}, mem_wdata,    32'd0);
      chk({tag, ".stall_M"},   32'(stall_M), 32'd0);
      check_w(tag);
   endtask

   initial begin
      zero_inputs();
      rst = 1'b1;
      model_bubble(); e_mis = 1'b0; e_to = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("reset");
      @(negedge clk);

      // Directed cases
      run_op("alu",      1, 0, 0, 5'd5,  32'h104, 32'h0, 32'h10, 0);
      run_op("load40",   1, 0, 1, 5'd7,  32'h108, 32'h0, 32'h40, 3);
      run_op("alu2",     1, 0, 0, 5'd9,  32'h10C, 32'h0, 32'h55, 0);
      run_op("st_mis",   0, 1, 0, 5'd0,  32'h110, 32'h1234, 32'h22, 0);
      run_op("alu3",     1, 0, 0, 5'd3,  32'h114, 32'h0, 32'h77, 0);
      run_op("st_to",    0, 1, 0, 5'd0,  32'h118, 32'hCAFE, 32'h80, 99);
      run_op("ld_edge",  1, 0, 1, 5'd12, 32'h11C, 32'h0, 32'h84, TO);
      run_op("both",     1, 1, 1, 5'd13, 32'h120, 32'hABCD, 32'h88, 1);
      run_op("b2b_ld",   1, 0, 1, 5'd14, 32'h124, 32'h0, 32'h8C, 1);

      // Reset in the middle of REQ, followed by a late ack.
      regwrt_M = 1; memwrite_M = 0; resultctrl_M = 1; RD_M = 5'd6;
      PC_1DEM = 32'h200; writedata_M = 0; ALUresult_M = 32'h100; mem_ack = 0;
      @(negedge clk);
      #1;
      chk("rstreq.mem_req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      zero_inputs();
      mem_ack = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      model_bubble(); e_mis = 1'b0; e_to = 1'b0;
      #1;
      check_all_zero("post_rst");
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check_all_zero("late_ack");
      @(negedge clk);
      run_op("ld_after_rst", 1, 0, 1, 5'd8, 32'h204, 32'h0, 32'h104, 2);

      // Random instruction stream
      for (int i = 0; i < 60; i++) begin
         int          kind;
         logic [31:0] a;
         kind = $urandom_range(0, 3);
         a    = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_op("rnd", 1'($urandom_range(0, 1)), kind[1], kind[0],
                5'($urandom), $urandom, $urandom, a, $urandom_range(1, TO + 2));
      end
      // Check the last retirement.
      zero_inputs();
      #1;
      check_w("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
